// File: rtl/sdram_responder.sv
// SDRAM device-side responder: decodes pin-level commands, tracks per-bank row state, serves a
// small word memory with CAS-latency read timing and latches the first protocol violation seen.
module sdram_responder #(
  parameter int MEM_AW = 12,
  parameter int T_RCD  = 2,
  parameter int T_RFC  = 4,
  parameter int T_MRD  = 3
) (
  input  logic        I_clk,
  input  logic        I_rst_n,
  input  logic        I_ram_nCS,
  input  logic        I_ram_nRAS,
  input  logic        I_ram_nCAS,
  input  logic        I_ram_nWE,
  input  logic [10:0] I_ram_A,
  input  logic [1:0]  I_ram_BA,
  input  logic [3:0]  I_ram_DQM,
  inout  wire  [31:0] IO_ram_DQ,
  output logic        O_init_done,
  output logic        O_err,
  output logic [2:0]  O_err_code,
  output logic [15:0] O_rd_count,
  output logic [15:0] O_wr_count
);

  typedef enum logic [2:0] {
    CmdLmr = 3'b000,
    CmdRef = 3'b001,
    CmdPre = 3'b010,
    CmdAct = 3'b011,
    CmdWr  = 3'b100,
    CmdRd  = 3'b101,
    CmdRsv = 3'b110,
    CmdNop = 3'b111
  } cmd_e;

  // Timers count edges since their start event minus one, saturating once the window is over.
  localparam logic [7:0] RCD_MIN1 = 8'(T_RCD - 1);
  localparam logic [7:0] RFC_MIN1 = 8'(T_RFC - 1);
  localparam logic [7:0] MRD_LAST = 8'(T_MRD - 1);

  localparam logic [2:0] E_ACT_OPEN  = 3'd1;
  localparam logic [2:0] E_IDLE_BANK = 3'd2;
  localparam logic [2:0] E_RCD       = 3'd3;
  localparam logic [2:0] E_RD_CLASH  = 3'd4;
  localparam logic [2:0] E_MODE      = 3'd5;
  localparam logic [2:0] E_REF_OPEN  = 3'd6;
  localparam logic [2:0] E_SEQ       = 3'd7;

  cmd_e        cmd;
  logic [3:0]  bank_act_q;
  logic [10:0] bank_row_q [4];
  logic [7:0]  rcd_cnt_q  [4];
  logic [7:0]  rfc_cnt_q;
  logic [7:0]  mrd_cnt_q;
  logic        mrd_run_q;
  logic        init_done_q;
  logic        cl3_q;
  logic        err_q;
  logic [2:0]  err_code_q;
  logic [15:0] rd_cnt_q;
  logic [15:0] wr_cnt_q;
  logic [3:1]  rd_v_q;
  logic [31:0] rd_d_q [1:3];
  logic [31:0] mem [2**MEM_AW];

  logic              is_acc;
  logic              bank_open;
  logic              rcd_early;
  logic              rfc_early;
  logic              rd_busy;
  logic              mode_ok;
  logic              do_act;
  logic              do_rd;
  logic              do_wr;
  logic              do_lmr;
  logic              do_pre;
  logic              do_ref;
  logic              rd_clash;
  logic              err_now;
  logic [2:0]        err_now_code;
  logic [MEM_AW-1:0] word_idx;
  logic              dq_oe;
  logic [31:0]       dq_out;

  always_comb begin
    cmd = I_ram_nCS ? CmdNop : cmd_e'({I_ram_nRAS, I_ram_nCAS, I_ram_nWE});
    if (cmd == CmdRsv) begin
      cmd = CmdNop;
    end
  end

  assign word_idx = MEM_AW'({I_ram_BA, bank_row_q[I_ram_BA], I_ram_A[7:0]});

  always_comb begin
    is_acc    = (cmd == CmdRd) || (cmd == CmdWr);
    bank_open = bank_act_q[I_ram_BA];
    rcd_early = rcd_cnt_q[I_ram_BA] < RCD_MIN1;
    rfc_early = (cmd != CmdNop) && (rfc_cnt_q < RFC_MIN1);
    // A write collides with any read whose data slot has not yet passed the bus.
    rd_busy   = cl3_q ? (|rd_v_q) : (|rd_v_q[2:1]);
    mode_ok   = ((I_ram_A[6:4] == 3'd2) || (I_ram_A[6:4] == 3'd3)) && (I_ram_A[2:0] == 3'd0);

    do_act   = (cmd == CmdAct) && init_done_q && !bank_open;
    do_rd    = (cmd == CmdRd) && init_done_q && bank_open;
    do_wr    = (cmd == CmdWr) && init_done_q && bank_open;
    do_lmr   = (cmd == CmdLmr);
    do_pre   = (cmd == CmdPre);
    do_ref   = (cmd == CmdRef);
    rd_clash = do_wr && rd_busy;

    err_now      = 1'b1;
    err_now_code = '0;
    if (((is_acc || (cmd == CmdAct)) && !init_done_q) || rfc_early) begin
      err_now_code = E_SEQ;
    end else if ((cmd == CmdAct) && bank_open) begin
      err_now_code = E_ACT_OPEN;
    end else if (is_acc && !bank_open) begin
      err_now_code = E_IDLE_BANK;
    end else if (is_acc && rcd_early) begin
      err_now_code = E_RCD;
    end else if (rd_clash) begin
      err_now_code = E_RD_CLASH;
    end else if (do_lmr && !mode_ok) begin
      err_now_code = E_MODE;
    end else if (do_ref && (|bank_act_q)) begin
      err_now_code = E_REF_OPEN;
    end else begin
      err_now = 1'b0;
    end
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      bank_act_q <= '0;
      for (int b = 0; b < 4; b++) begin
        bank_row_q[b] <= '0;
        rcd_cnt_q[b]  <= RCD_MIN1;
      end
      rfc_cnt_q   <= RFC_MIN1;
      mrd_cnt_q   <= '0;
      mrd_run_q   <= 1'b0;
      init_done_q <= 1'b0;
      cl3_q       <= 1'b0;
      rd_v_q      <= '0;
      for (int s = 1; s <= 3; s++) begin
        rd_d_q[s] <= '0;
      end
      err_q      <= 1'b0;
      err_code_q <= '0;
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (rcd_cnt_q[b] != RCD_MIN1) begin
          rcd_cnt_q[b] <= rcd_cnt_q[b] + 8'd1;
        end
      end

      if (do_act) begin
        bank_act_q[I_ram_BA] <= 1'b1;
        bank_row_q[I_ram_BA] <= I_ram_A;
        rcd_cnt_q[I_ram_BA]  <= '0;
      end
      if (do_pre) begin
        if (I_ram_A[10]) begin
          bank_act_q <= '0;
        end else begin
          bank_act_q[I_ram_BA] <= 1'b0;
        end
      end
      // Auto-precharge closes the bank once the access has been taken.
      if ((do_rd || do_wr) && I_ram_A[10]) begin
        bank_act_q[I_ram_BA] <= 1'b0;
      end

      if (do_ref) begin
        rfc_cnt_q <= '0;
      end else if (rfc_cnt_q != RFC_MIN1) begin
        rfc_cnt_q <= rfc_cnt_q + 8'd1;
      end

      if (do_lmr) begin
        cl3_q     <= mode_ok && (I_ram_A[6:4] == 3'd3);
        mrd_run_q <= 1'b1;
        mrd_cnt_q <= '0;
      end else if (mrd_run_q) begin
        if (mrd_cnt_q == MRD_LAST) begin
          init_done_q <= 1'b1;
          mrd_run_q   <= 1'b0;
        end else begin
          mrd_cnt_q <= mrd_cnt_q + 8'd1;
        end
      end

      rd_d_q[1] <= mem[word_idx];
      rd_d_q[2] <= rd_d_q[1];
      rd_d_q[3] <= rd_d_q[2];
      rd_v_q    <= rd_clash ? 3'b000 : {rd_v_q[2:1], do_rd};

      if (do_rd && (rd_cnt_q != 16'hFFFF)) begin
        rd_cnt_q <= rd_cnt_q + 16'd1;
      end
      if (do_wr && (wr_cnt_q != 16'hFFFF)) begin
        wr_cnt_q <= wr_cnt_q + 16'd1;
      end

      if (err_now && !err_q) begin
        err_q      <= 1'b1;
        err_code_q <= err_now_code;
      end
    end
  end

  // Storage survives reset, so it sits outside the reset domain.
  always_ff @(posedge I_clk) begin
    if (do_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (!I_ram_DQM[i]) begin
          mem[word_idx][8*i +: 8] <= IO_ram_DQ[8*i +: 8];
        end
      end
    end
  end

  assign dq_oe     = cl3_q ? rd_v_q[3] : rd_v_q[2];
  assign dq_out    = cl3_q ? rd_d_q[3] : rd_d_q[2];
  assign IO_ram_DQ = dq_oe ? dq_out : 32'hzzzz_zzzz;

  assign O_init_done = init_done_q;
  assign O_err       = err_q;
  assign O_err_code  = err_code_q;
  assign O_rd_count  = rd_cnt_q;
  assign O_wr_count  = wr_cnt_q;

endmodule

// File: tb/tb_sdram_responder.sv
// Directed bench for sdram_responder: init, write/read, masking, timing errors, CL3 and
// read/write collision; the DQ bus is pulled up so a released bus reads as all ones.
module tb_sdram_responder;

  localparam logic [2:0] C_LMR = 3'b000;
  localparam logic [2:0] C_REF = 3'b001;
  localparam logic [2:0] C_PRE = 3'b010;
  localparam logic [2:0] C_ACT = 3'b011;
  localparam logic [2:0] C_WR  = 3'b100;
  localparam logic [2:0] C_RD  = 3'b101;
  localparam logic [31:0] RELEASED = 32'hFFFF_FFFF;

  logic        I_clk      = 1'b0;
  logic        I_rst_n    = 1'b1;
  logic        I_ram_nCS  = 1'b1;
  logic        I_ram_nRAS = 1'b1;
  logic        I_ram_nCAS = 1'b1;
  logic        I_ram_nWE  = 1'b1;
  logic [10:0] I_ram_A    = '0;
  logic [1:0]  I_ram_BA   = '0;
  logic [3:0]  I_ram_DQM  = 4'hF;
  wire  [31:0] IO_ram_DQ;
  logic [31:0] dq_drv     = '0;
  logic        dq_en      = 1'b0;
  logic        O_init_done;
  logic        O_err;
  logic [2:0]  O_err_code;
  logic [15:0] O_rd_count;
  logic [15:0] O_wr_count;

  int n_checks = 0;
  int n_errors = 0;

  assign IO_ram_DQ = dq_en ? dq_drv : 32'hzzzz_zzzz;
  pullup pu_dq (IO_ram_DQ);

  always #5 I_clk = ~I_clk;

  sdram_responder dut (
    .I_clk       (I_clk),
    .I_rst_n     (I_rst_n),
    .I_ram_nCS   (I_ram_nCS),
    .I_ram_nRAS  (I_ram_nRAS),
    .I_ram_nCAS  (I_ram_nCAS),
    .I_ram_nWE   (I_ram_nWE),
    .I_ram_A     (I_ram_A),
    .I_ram_BA    (I_ram_BA),
    .I_ram_DQM   (I_ram_DQM),
    .IO_ram_DQ   (IO_ram_DQ),
    .O_init_done (O_init_done),
    .O_err       (O_err),
    .O_err_code  (O_err_code),
    .O_rd_count  (O_rd_count),
    .O_wr_count  (O_wr_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Sets up one command for the next rising edge; outputs seen here reflect the previous edge.
  task automatic issue(input logic [2:0] c, input logic [1:0] ba, input logic [10:0] a,
                       input logic [3:0] dqm, input logic [31:0] d);
    @(negedge I_clk);
    I_ram_nCS = 1'b0;
    {I_ram_nRAS, I_ram_nCAS, I_ram_nWE} = c;
    I_ram_BA  = ba;
    I_ram_A   = a;
    I_ram_DQM = dqm;
    dq_drv    = d;
    dq_en     = (c == C_WR);
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge I_clk);
      I_ram_nCS = 1'b1;
      {I_ram_nRAS, I_ram_nCAS, I_ram_nWE} = 3'b111;
      I_ram_DQM = 4'hF;
      dq_en     = 1'b0;
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_dq"},   IO_ram_DQ, RELEASED);
    check({tag, "_init"}, 32'(O_init_done), 32'd0);
    check({tag, "_err"},  32'(O_err), 32'd0);
    check({tag, "_code"}, 32'(O_err_code), 32'd0);
    check({tag, "_rd"},   32'(O_rd_count), 32'd0);
    check({tag, "_wr"},   32'(O_wr_count), 32'd0);
  endtask

  initial begin
    #1 I_rst_n = 1'b0;
    repeat (2) @(negedge I_clk);
    check_cleared("reset");
    I_rst_n = 1'b1;

    // Power-up sequence, CL=2.
    issue(C_PRE, 2'd0, 11'h400, 4'hF, '0);
    issue(C_REF, 2'd0, 11'h000, 4'hF, '0);
    nop(3);
    issue(C_REF, 2'd0, 11'h000, 4'hF, '0);
    nop(3);
    issue(C_LMR, 2'd0, 11'h020, 4'hF, '0);
    nop(3);
    check("init_m2", 32'(O_init_done), 32'd0);
    nop(1);
    check("init_m3", 32'(O_init_done), 32'd1);
    check("init_err", 32'(O_err), 32'd0);

    // Full write with auto-precharge, reopen, read back at CL=2.
    issue(C_ACT, 2'd1, 11'd5, 4'hF, '0);
    nop(1);
    issue(C_WR, 2'd1, 11'h403, 4'h0, 32'hDEADBEEF);
    issue(C_ACT, 2'd1, 11'd5, 4'hF, '0);
    nop(1);
    issue(C_RD, 2'd1, 11'h003, 4'hF, '0);
    nop(1);
    check("cl2_k", IO_ram_DQ, RELEASED);
    nop(1);
    check("cl2_k1", IO_ram_DQ, 32'hDEADBEEF);
    nop(1);
    check("cl2_k2", IO_ram_DQ, RELEASED);
    check("cnt_rd1", 32'(O_rd_count), 32'd1);
    check("cnt_wr1", 32'(O_wr_count), 32'd1);
    check("no_err", 32'(O_err), 32'd0);

    // Byte-masked write over the same word.
    issue(C_WR, 2'd1, 11'h003, 4'b0101, 32'h11223344);
    issue(C_RD, 2'd1, 11'h003, 4'hF, '0);
    nop(2);
    check("masked", IO_ram_DQ, 32'h11AD33EF);
    nop(1);
    check("cnt_wr2", 32'(O_wr_count), 32'd2);

    // tRCD violation still reads; bank bits fall outside the 12-bit index, same word.
    issue(C_ACT, 2'd2, 11'd5, 4'hF, '0);
    issue(C_RD, 2'd2, 11'h003, 4'hF, '0);
    nop(1);
    check("rcd_err", 32'(O_err), 32'd1);
    check("rcd_code", 32'(O_err_code), 32'd3);
    nop(1);
    check("rcd_data", IO_ram_DQ, 32'h11AD33EF);
    nop(1);
    issue(C_REF, 2'd0, 11'h000, 4'hF, '0);
    nop(1);
    check("sticky_code", 32'(O_err_code), 32'd3);
    check("cnt_rd3", 32'(O_rd_count), 32'd3);

    // Reset while read data is on the bus.
    nop(4);
    issue(C_RD, 2'd1, 11'h003, 4'hF, '0);
    nop(2);
    check("pre_rst_dq", IO_ram_DQ, 32'h11AD33EF);
    #2 I_rst_n = 1'b0;
    #1;
    check_cleared("midrd_rst");
    @(negedge I_clk);
    I_rst_n = 1'b1;
    issue(C_RD, 2'd1, 11'h003, 4'hF, '0);
    nop(1);
    check("preinit_err", 32'(O_err), 32'd1);
    check("preinit_code", 32'(O_err_code), 32'd7);
    check("preinit_rd", 32'(O_rd_count), 32'd0);
    nop(1);
    check("preinit_dq", IO_ram_DQ, RELEASED);

    // CL=3 after a fresh reset; memory contents must have survived.
    @(negedge I_clk);
    I_rst_n = 1'b0;
    @(negedge I_clk);
    I_rst_n = 1'b1;
    issue(C_LMR, 2'd0, 11'h030, 4'hF, '0);
    nop(4);
    check("cl3_init", 32'(O_init_done), 32'd1);
    issue(C_ACT, 2'd0, 11'd5, 4'hF, '0);
    nop(1);
    issue(C_RD, 2'd0, 11'h003, 4'hF, '0);
    nop(2);
    check("cl3_k1", IO_ram_DQ, RELEASED);
    nop(1);
    check("cl3_k2", IO_ram_DQ, 32'h11AD33EF);
    nop(1);
    check("cl3_k3", IO_ram_DQ, RELEASED);
    check("cl3_no_err", 32'(O_err), 32'd0);

    // Write into a pending read: flagged, write lands, read data dropped.
    issue(C_RD, 2'd0, 11'h003, 4'hF, '0);
    issue(C_WR, 2'd0, 11'h003, 4'h0, 32'hCAFEF00D);
    nop(1);
    check("clash_err", 32'(O_err), 32'd1);
    check("clash_code", 32'(O_err_code), 32'd4);
    nop(1);
    check("clash_dq2", IO_ram_DQ, RELEASED);
    nop(1);
    check("clash_dq3", IO_ram_DQ, RELEASED);
    issue(C_RD, 2'd0, 11'h003, 4'hF, '0);
    nop(3);
    check("clash_wdata", IO_ram_DQ, 32'hCAFEF00D);
    check("cnt_rd_cl3", 32'(O_rd_count), 32'd3);
    check("cnt_wr_cl3", 32'(O_wr_count), 32'd1);
    nop(2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "bench did not complete");
  end

endmodule

// File: doc/sdram_responder.md
SDRAM_RESPONDER -- requirements
Module: sdram_responder

Interface
REQ-001 Parameter MEM_AW, default 12: log2 of internal 32-bit word storage depth.
REQ-002 Parameter T_RCD, default 2: minimum cycles from ACTIVATE to READ/WRITE on the same bank.
REQ-003 Parameter T_RFC, default 4: minimum cycles from AUTO REFRESH to any non-NOP command.
REQ-004 Parameter T_MRD, default 3: cycles from LOAD MODE until O_init_done rises.
REQ-005 Clocking and reset SHALL be as follows: reset I_rst_n, asynchronous, active-low; clock I_clk.
REQ-006 I_clk  in  1  SDRAM pin clock; all sampling on rising edge.
REQ-007 I_rst_n  in  1  asynchronous active-low reset.
REQ-008 I_ram_nCS, I_ram_nRAS, I_ram_nCAS, I_ram_nWE  in  1 each  command pins.
REQ-009 I_ram_A  in  11  row, column, or mode; A[10] = all-banks/auto-precharge.
REQ-010 I_ram_BA  in  2  bank select.
REQ-011 I_ram_DQM  in  4  write byte mask, bit i masks DQ[8i+7:8i].
REQ-012 IO_ram_DQ  inout  32  data; high-Z unless driving read data.
REQ-013 O_init_done  out  1  mode register loaded and T_MRD elapsed.
REQ-014 O_err  out  1  sticky protocol-violation flag.
REQ-015 O_err_code  out  3  code of the first violation; held until reset.
REQ-016 O_rd_count, O_wr_count  out  16 each  accepted READ/WRITE counts, saturating at 16'hFFFF.

Function
REQ-017 A command SHALL be decoded only when I_ram_nCS=0 at the rising edge. {nRAS,nCAS,nWE}: 000 LOAD MODE, 001 REFRESH, 010 PRECHARGE, 011 ACTIVATE, 100 WRITE, 101 READ, 111 NOP; 110 SHALL be treated as NOP.
REQ-018 Per-bank state SHALL be IDLE or ACTIVE, with an 11-bit open-row register and a saturating T_RCD counter.
REQ-019 ACTIVATE on an IDLE bank: bank -> ACTIVE, row <- I_ram_A, counter cleared. ACTIVATE on an ACTIVE bank: error code 1, state unchanged.
REQ-020 PRECHARGE: A[10]=1 -> all banks IDLE; A[10]=0 -> only bank BA IDLE. Precharge of an IDLE bank is legal.
REQ-021 READ/WRITE on an IDLE bank: error 2, command ignored. Issued fewer than T_RCD cycles after ACTIVATE: error 3, command still executed.
REQ-022 Word index SHALL be the low MEM_AW bits of {BA, row, A[7:0]}.
REQ-023 WRITE SHALL capture IO_ram_DQ at the command edge, with byte i written only when DQM[i]=0.
REQ-024 READ sampled at edge k: responder drives mem[index] onto DQ from just after edge k+CL-1 until just after edge k+CL, so data is stable at edge k+CL. DQM SHALL be ignored for reads.
REQ-025 Reads SHALL be pipelined: back-to-back READs each produce one data cycle. WRITE while read data is pending or being driven: error 4; write executed, read data suppressed.
REQ-026 READ/WRITE with A[10]=1 SHALL return the bank to IDLE after the access. A[10]=0 leaves the bank ACTIVE.
REQ-027 LOAD MODE: CL <- A[6:4], BL <- A[2:0]. CL not 2 or 3, or BL not 0: error 5, CL forced to 2. O_init_done SHALL rise T_MRD cycles after the command.
REQ-028 REFRESH with any bank ACTIVE: error 6. Any non-NOP command within T_RFC cycles after REFRESH: error 7.
REQ-029 READ/WRITE/ACTIVATE before O_init_done: error 7 and command ignored. PRECHARGE and REFRESH SHALL be legal before init.
REQ-030 The first error SHALL set O_err and latch O_err_code. Later errors SHALL leave O_err_code unchanged.

Reset
REQ-031 While I_rst_n=0, the following SHALL apply asynchronously:
- all banks IDLE, CL=2, read pipeline flushed, DQ high-Z;
- O_init_done=0, O_err=0, O_err_code=0, both counters 0.
REQ-032 Memory contents SHALL NOT be cleared. Reset asserted during a read data cycle SHALL release DQ immediately.

Verification
REQ-033 Init sequence: PRECHARGE A10=1, two REFRESH T_RFC apart, LOAD MODE A=11'h020 -> O_init_done=1 exactly 3 cycles later, O_err=0.
REQ-034 ACTIVATE BA=1 row=5, WRITE col=3 data 32'hDEADBEEF DQM=4'b0000 A10=1, ACTIVATE, READ -> 32'hDEADBEEF on DQ at edge k+2. O_wr_count=1, O_rd_count=1.
REQ-035 Masked write: 32'h11223344 with DQM=4'b0101 over 32'hDEADBEEF -> readback 32'h11AD33EF.
REQ-036 READ issued 1 cycle after ACTIVATE -> O_err=1, O_err_code=3, data still returned. A following REFRESH with a bank active -> code remains 3.
REQ-037 Assert I_rst_n=0 mid-read (between edges k+1 and k+2) -> DQ high-Z immediately, all outputs 0. A subsequent READ before init -> error 7.
